// File: rtl/rs_dec_corr_sched.sv
// RS correction scheduler: two-bank codeword buffer paired with Chien/Forney results and
// replayed behind a one-cycle corrector start pulse. Optional feature: RS_SCHED_FAIL_DROP_EN.
module rs_dec_corr_sched #(
    parameter int unsigned SYM_BW = 8,
    parameter int unsigned N_NUM  = 255,
    parameter int unsigned T_NUM  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_val,
    input  logic [SYM_BW-1:0]       in_sym,
    output logic                    in_rdy,
    input  logic                    res_val,
    input  logic                    res_fail,
    input  logic [SYM_BW*T_NUM-1:0] res_err_loc,
    input  logic [SYM_BW*T_NUM-1:0] res_err_val,
    output logic                    start,
    output logic [SYM_BW*T_NUM-1:0] cor_err_loc,
    output logic [SYM_BW*T_NUM-1:0] cor_err_val,
    output logic [SYM_BW-1:0]       symb_cnt,
    output logic [SYM_BW-1:0]       symb_with_err,
    output logic                    res_ovf
`ifdef RS_SCHED_FAIL_DROP_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int unsigned VW = SYM_BW * T_NUM;
    localparam int unsigned AW = (N_NUM > 1) ? $clog2(N_NUM) : 1;

    typedef enum logic [2:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_RESULT_OK,
        B_READING
    } bank_st_e;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_START,
        RD_WAIT1,
        RD_WAIT2,
        RD_REPLAY
    } rd_st_e;

    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic [SYM_BW-1:0] mem_q  [2][N_NUM];
    logic [VW-1:0]     rloc_q [2];
    logic [VW-1:0]     rval_q [2];

    logic              wr_bank_q, wr_bank_d;
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic              att_bank_q, att_bank_d;
    logic              nxt_bank_q, nxt_bank_d;
    logic              cur_bank_q, cur_bank_d;
    rd_st_e            state_q, state_d;
    logic [SYM_BW-1:0] cnt_q, cnt_d;
    logic [SYM_BW-1:0] sym_q, sym_d;
    logic [VW-1:0]     cor_loc_q, cor_loc_d;
    logic [VW-1:0]     cor_val_q, cor_val_d;
    logic              ovf_q, ovf_d;

    logic wr_fire, wr_last, cmpl;
    logic att_hit, att_go, drop;
    logic rel, go, nxt_ready;

    assign in_rdy  = (bank_q[wr_bank_q] == B_EMPTY) || (bank_q[wr_bank_q] == B_FILLING);
    assign wr_fire = in_val & in_rdy;
    assign wr_last = (wr_cnt_q == 8'(N_NUM - 1));
    assign cmpl    = wr_fire & wr_last;

    // A bank completing in this very cycle is treated as already FULL.
    assign att_hit = (bank_q[att_bank_q] == B_FULL) | (cmpl & (wr_bank_q == att_bank_q));
    assign att_go  = res_val & att_hit;

`ifdef RS_SCHED_FAIL_DROP_EN
    assign drop = att_go & res_fail;
`else
    assign drop = 1'b0;
    logic unused_res_fail;
    assign unused_res_fail = res_fail;
`endif

    assign rel       = (state_q == RD_REPLAY) && (cnt_q == SYM_BW'(N_NUM));
    assign nxt_ready = (bank_q[nxt_bank_q] == B_RESULT_OK) |
                       (att_go & ~drop & (att_bank_q == nxt_bank_q));
    // Launch straight from IDLE or from the last replay cycle, so no dead cycle between blocks.
    assign go        = ((state_q == RD_IDLE) | rel) & nxt_ready;

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        att_bank_d = att_bank_q ^ att_go;
        nxt_bank_d = nxt_bank_q ^ go ^ drop;
        cur_bank_d = go ? nxt_bank_q : cur_bank_q;
        ovf_d      = ovf_q | (res_val & ~att_hit);
        if (wr_fire) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 8'd1;
            end
        end
        for (int unsigned b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire && (wr_bank_q == 1'(b)))
                bank_d[b] = wr_last ? B_FULL : B_FILLING;
            if (att_go && (att_bank_q == 1'(b)))
                bank_d[b] = drop ? B_EMPTY : B_RESULT_OK;
            if (go && (nxt_bank_q == 1'(b)))
                bank_d[b] = B_READING;
            if (rel && (cur_bank_q == 1'(b)))
                bank_d[b] = B_EMPTY;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        cor_loc_d = cor_loc_q;
        cor_val_d = cor_val_q;
        if (go) begin
            if (bank_q[nxt_bank_q] == B_RESULT_OK) begin
                cor_loc_d = rloc_q[nxt_bank_q];
                cor_val_d = rval_q[nxt_bank_q];
            end else begin
                cor_loc_d = res_err_loc;
                cor_val_d = res_err_val;
            end
        end
        case (state_q)
            RD_IDLE:  if (go) state_d = RD_START;
            RD_START: state_d = RD_WAIT1;
            RD_WAIT1: state_d = RD_WAIT2;
            RD_WAIT2: begin
                // Read for symbol 1 is issued here so count and data change together.
                state_d = RD_REPLAY;
                cnt_d   = SYM_BW'(1);
                sym_d   = mem_q[cur_bank_q][AW'(cnt_q)];
            end
            RD_REPLAY: begin
                if (rel) begin
                    state_d = go ? RD_START : RD_IDLE;
                    cnt_d   = '0;
                    sym_d   = '0;
                end else begin
                    cnt_d = cnt_q + SYM_BW'(1);
                    sym_d = mem_q[cur_bank_q][AW'(cnt_q)];
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem_q[wr_bank_q][AW'(wr_cnt_q)] <= in_sym;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            rloc_q[0]  <= '0;
            rloc_q[1]  <= '0;
            rval_q[0]  <= '0;
            rval_q[1]  <= '0;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            att_bank_q <= 1'b0;
            nxt_bank_q <= 1'b0;
            cur_bank_q <= 1'b0;
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            sym_q      <= '0;
            cor_loc_q  <= '0;
            cor_val_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            if (att_go && !drop) begin
                rloc_q[att_bank_q] <= res_err_loc;
                rval_q[att_bank_q] <= res_err_val;
            end
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            att_bank_q <= att_bank_d;
            nxt_bank_q <= nxt_bank_d;
            cur_bank_q <= cur_bank_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_q      <= sym_d;
            cor_loc_q  <= cor_loc_d;
            cor_val_q  <= cor_val_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef RS_SCHED_FAIL_DROP_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

    assign start         = (state_q == RD_START);
    assign cor_err_loc   = cor_loc_q;
    assign cor_err_val   = cor_val_q;
    assign symb_cnt      = cnt_q;
    assign symb_with_err = sym_q;
    assign res_ovf       = ovf_q;

endmodule
